// File: rtl/dmem_byte_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_byte_arbiter
//
// Lets two 32-bit word requesters share one byte-wide data memory that has a
// one-cycle synchronous read. Each word access is split into four
// little-endian byte beats at base, base+1, base+2 and base+3 (modulo the
// memory size). The two ports are arbitrated round-robin. Each transaction
// ends with a single-cycle ack on the port that owns it.
//
// Timeline of one transaction (reads and writes take the same time):
//   IDLE (request sampled) -> BUSY beat 0..3 -> RESP (ack) -> IDLE
//
// Ports
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   a_req_i / b_req_i    request; hold it with its fields stable until the ack
//   a_we_i  / b_we_i     1 = word write, 0 = word read
//   a_addr_i/ b_addr_i   byte address; only the low ADDR_W bits are used
//   a_wdata_i/b_wdata_i  write data
//   a_ack_o / b_ack_o    one-cycle completion pulse
//   a_rdata_o/b_rdata_o  read data; valid with the ack of a read, then held
//   mem_addr_o           byte address to the memory
//   mem_we_o             byte write strobe
//   mem_wdata_o          byte write data
//   mem_rdata_i          byte read data for the address of the previous cycle
//   busy_o               a transaction is in flight (BUSY or RESP)
//   grant_o              current or most recent owner (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module dmem_byte_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [31:0]       a_addr_i,
  input  logic [31:0]       a_wdata_i,
  output logic              a_ack_o,
  output logic [31:0]       a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [31:0]       b_addr_i,
  input  logic [31:0]       b_wdata_i,
  output logic              b_ack_o,
  output logic [31:0]       b_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              grant_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_beat;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [23:0]       r_rbuf;
  logic [31:0]       r_a_rdata;
  logic [31:0]       r_b_rdata;

  logic              w_start;
  logic              w_pick_b;
  logic              w_in_resp;
  logic [31:0]       w_word;
  logic              w_unused;

  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  idx);
    logic [7:0] res;
    case (idx)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      default: res = word[31:24];
    endcase
    return res;
  endfunction

  // Round-robin: on a tie the port that did not win last time gets the grant.
  // last_grant resets to B, so A wins the first tie after reset.
  assign w_pick_b  = b_req_i & (~a_req_i | ~r_last_grant);
  assign w_start   = (r_state == S_IDLE) & (a_req_i | b_req_i);
  assign w_in_resp = (r_state == S_RESP);

  // Byte 3 of a read arrives in RESP and is passed straight through, so the
  // full word is visible in the same cycle as the ack.
  assign w_word    = {mem_rdata_i, r_rbuf};

  assign a_rdata_o = (w_in_resp & ~r_grant & ~r_we) ? w_word : r_a_rdata;
  assign b_rdata_o = (w_in_resp &  r_grant & ~r_we) ? w_word : r_b_rdata;
  assign grant_o   = r_grant;

  // Address bits above the memory size are ignored by design.
  assign w_unused  = ^{a_addr_i[31:ADDR_W], b_addr_i[31:ADDR_W]};

  always_comb begin
    w_state_nxt = r_state;
    a_ack_o     = 1'b0;
    b_ack_o     = 1'b0;
    busy_o      = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        busy_o     = 1'b1;
        // The addition is ADDR_W bits wide, so the address wraps at the top.
        mem_addr_o = r_base + ADDR_W'(r_beat);
        if (r_we) begin
          // A reset that lands on a beat suppresses that beat's byte, so only
          // bytes from beats that completed before the reset reach memory.
          mem_we_o    = ~rst_i;
          mem_wdata_o = byte_sel(r_wdata, r_beat);
        end
        if (r_beat == 2'd3) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        busy_o      = 1'b1;
        a_ack_o     = ~r_grant;
        b_ack_o     = r_grant;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, beat counter, grant and the per-port read-data hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_beat       <= 2'd0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_grant      <= w_pick_b;
        r_last_grant <= w_pick_b;
        r_beat       <= 2'd0;
      end else if (r_state == S_BUSY) begin
        r_beat <= r_beat + 2'd1;
      end
      if (w_in_resp && !r_we) begin
        if (r_grant) r_b_rdata <= w_word;
        else         r_a_rdata <= w_word;
      end
    end
  end

  // Transaction fields and read assembly: the fields are captured at the grant,
  // so later changes on the ports cannot disturb the transaction in flight.
  always_ff @(posedge clk_i) begin
    if (w_start) begin
      r_we    <= w_pick_b ? b_we_i    : a_we_i;
      r_base  <= w_pick_b ? b_addr_i[ADDR_W-1:0] : a_addr_i[ADDR_W-1:0];
      r_wdata <= w_pick_b ? b_wdata_i : a_wdata_i;
    end
    // Memory data lags the address by one cycle: at beat k the bus holds
    // the byte for beat k-1.
    if (r_state == S_BUSY && !r_we) begin
      case (r_beat)
        2'd1:    r_rbuf[7:0]   <= mem_rdata_i;
        2'd2:    r_rbuf[15:8]  <= mem_rdata_i;
        2'd3:    r_rbuf[23:16] <= mem_rdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_byte_arbiter.sv
module tb_dmem_byte_arbiter;
  localparam int ADDR_W = 5;
  localparam int MSZ    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req, a_we, a_ack;
  logic [31:0]       a_addr, a_wdata, a_rdata;
  logic              b_req, b_we, b_ack;
  logic [31:0]       b_addr, b_wdata, b_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              busy, grant;

  always #5 clk = ~clk;

  dmem_byte_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_ack_o(a_ack), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_ack_o(b_ack), .b_rdata_o(b_rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .grant_o(grant)
  );

  int errs    = 0;
  int checks  = 0;
  int we_viol = 0;

  logic        mem_load;
  logic [7:0]  mem  [MSZ];
  logic [7:0]  gold [MSZ];
  logic [31:0] hold [2];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [7:0]        d;
  } beat_t;
  beat_t blog [$];

  typedef struct {
    bit          p;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 17 + 1) & 255);
  endfunction

  // Byte memory with one-cycle synchronous read
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= init_byte(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Beat log: every BUSY cycle; write strobe anywhere else is a violation
  always @(negedge clk) begin
    if (busy && !a_ack && !b_ack)
      blog.push_back('{addr: mem_addr, we: mem_we, d: mem_wdata});
    else if (mem_we)
      we_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input int k);
    return (int'(addr[ADDR_W-1:0]) + k) % MSZ;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] addr);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = gold[widx(addr, k)];
    return w;
  endfunction

  task automatic gold_wr(input logic [31:0] addr, input logic [31:0] wd);
    for (int k = 0; k < 4; k++) gold[widx(addr, k)] = wd[8*k +: 8];
  endtask

  task automatic check_log(input string name, input logic [31:0] addr,
                           input logic we, input logic [31:0] wd);
    chk({name, " beats"}, 32'(blog.size()), 32'd4);
    if (blog.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s beat%0d addr", name, k), 32'(blog[k].addr), 32'(widx(addr, k)));
        chk($sformatf("%s beat%0d we", name, k), 32'(blog[k].we), 32'(we));
        if (we) chk($sformatf("%s beat%0d data", name, k), 32'(blog[k].d), 32'(wd[8*k +: 8]));
      end
    end
  endtask

  task automatic drive(input bit p, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (!p) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
    else    begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
  endtask

  // Model the completion of one transaction on port p
  task automatic model_done(input string name, input bit p, input bit we,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd);
    logic [31:0] exp;
    if (we) begin
      chk({name, " rdata hold"}, rd, hold[p]);
      gold_wr(addr, wd);
    end else begin
      exp = gold_rd(addr);
      chk({name, " rdata"}, rd, exp);
      hold[p] = exp;
    end
  endtask

  // Single transaction on an idle arbiter; called at a falling edge
  task automatic apply_txn(input string name, input bit p, input bit we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd);
    int lat;
    blog.delete();
    drive(p, 1'b1, we, addr, wd);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(p ? b_ack : a_ack) && lat < 20);
    rd = p ? b_rdata : a_rdata;
    chk({name, " latency"}, 32'(lat), 32'd5);
    chk({name, " grant"}, 32'(grant), 32'(p));
    check_log(name, addr, we, wd);
    model_done(name, p, we, addr, wd, rd);
    drive(p, 1'b0, we, addr, wd);
    @(negedge clk);
  endtask

  // A requests at once, B after b_delay cycles; A's address is scrambled mid-BUSY
  task automatic pair(input string name, input int b_delay,
                      input bit awe, input logic [31:0] aad, input logic [31:0] awd,
                      input bit bwe, input logic [31:0] bad, input logic [31:0] bwd);
    int at, bt;
    at = -1;
    bt = -1;
    blog.delete();
    drive(1'b0, 1'b1, awe, aad, awd);
    if (b_delay == 0) drive(1'b1, 1'b1, bwe, bad, bwd);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == b_delay) drive(1'b1, 1'b1, bwe, bad, bwd);
      if (n == 2) a_addr = ~aad;
      if (a_ack && at < 0) begin
        at = n;
        chk({name, " A grant"}, 32'(grant), 32'd0);
        check_log({name, " A"}, aad, awe, awd);
        model_done({name, " A"}, 1'b0, awe, aad, awd, a_rdata);
        a_req = 1'b0;
      end
      if (b_ack && bt < 0) begin
        bt = n;
        chk({name, " B grant"}, 32'(grant), 32'd1);
        model_done({name, " B"}, 1'b1, bwe, bad, bwd, b_rdata);
        b_req = 1'b0;
      end
      if (at >= 0 && bt >= 0) break;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk({name, " A ack cycle"}, 32'(at), 32'd5);
    chk({name, " B ack cycle"}, 32'(bt), 32'd11);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold[0] = '0;
    hold[1] = '0;
  endtask

  initial begin
    vec_t        vecs [10];
    logic [31:0] rd, rd1, rd2;
    logic [7:0]  g12, g13;
    int          t1, t2, bad, acks;

    rst      = 1'b1;
    mem_load = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < MSZ; i++) gold[i] = init_byte(i);
    hold[0] = '0;
    hold[1] = '0;

    vecs[0] = '{1'b0, 1'b1, 32'h04, 32'h11223344, 32'h00000000};
    vecs[1] = '{1'b0, 1'b0, 32'h04, 32'h0,        32'h11223344};
    vecs[2] = '{1'b1, 1'b1, 32'h1E, 32'hCAFEF00D, 32'h00000000};
    vecs[3] = '{1'b0, 1'b0, 32'h1E, 32'h0,        32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b0, 32'h04, 32'h0,        32'h11223344};
    vecs[5] = '{1'b0, 1'b1, 32'h05, 32'hA5A50102, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'h04, 32'h0,        32'hA5010244};
    vecs[7] = '{1'b0, 1'b0, 32'h1F, 32'h0,        32'h23CAFEF0};
    vecs[8] = '{1'b1, 1'b1, 32'h07, 32'h0BADF00D, 32'hA5010244};
    vecs[9] = '{1'b0, 1'b0, 32'h06, 32'h0,        32'hADF00D01};

    repeat (3) @(negedge clk);
    chk("rst a_ack", 32'(a_ack), 32'd0);
    chk("rst b_ack", 32'(b_ack), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst a_rdata", a_rdata, 32'd0);
    chk("rst b_rdata", b_rdata, 32'd0);
    rst      = 1'b0;
    mem_load = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply_txn($sformatf("vec%0d", i), vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wd, rd);
      chk($sformatf("vec%0d table", i), rd, vecs[i].exp);
    end

    // Simultaneous requests straight out of reset, then a second tie
    do_reset();
    pair("pair1", 0, 1'b0, 32'h00, 32'h0, 1'b1, 32'h08, 32'hDEADBEEF);
    pair("pair2", 0, 1'b0, 32'h08, 32'h0, 1'b1, 32'h0C, 32'h01020304);

    // B arrives while A is busy
    pair("overlap", 2, 1'b1, 32'h14, 32'h55667788, 1'b0, 32'h04, 32'h0);

    // Reset during beat 2 of a write
    g12 = gold[18];
    g13 = gold[19];
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hAABBCCDD);
    repeat (3) @(negedge clk);
    chk("rstmid beat2 addr", 32'(mem_addr), 32'h12);
    chk("rstmid beat2 busy", 32'(busy), 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid ack", 32'(a_ack), 32'd0);
    chk("rstmid mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    hold[0] = '0;
    hold[1] = '0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
    end
    chk("rstmid no ack", 32'(acks), 32'd0);
    chk("rstmid byte10", 32'(mem[16]), 32'hDD);
    chk("rstmid byte11", 32'(mem[17]), 32'hCC);
    chk("rstmid byte12", 32'(mem[18]), 32'(g12));
    chk("rstmid byte13", 32'(mem[19]), 32'(g13));
    gold[16] = 8'hDD;
    gold[17] = 8'hCC;

    // Request held one cycle past the ack -> a second read
    apply_txn("bprime", 1'b1, 1'b0, 32'h08, 32'h0, rd);
    t1 = -1;
    t2 = -1;
    bad = 0;
    rd1 = '0;
    rd2 = '0;
    drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b_rdata !== hold[1]) bad++;
      if (a_ack) begin
        if (t1 < 0) begin
          t1 = n;
          rd1 = a_rdata;
        end else begin
          t2 = n;
          rd2 = a_rdata;
          break;
        end
      end
    end
    a_req = 1'b0;
    @(negedge clk);
    chk("held first ack", 32'(t1), 32'd5);
    chk("held second ack", 32'(t2), 32'd11);
    chk("held rdata1", rd1, gold_rd(32'h14));
    chk("held rdata2", rd2, gold_rd(32'h14));
    chk("held b_rdata changes", 32'(bad), 32'd0);
    hold[0] = gold_rd(32'h14);

    // Randomized single transactions against the byte-array model
    for (int i = 0; i < 40; i++) begin
      apply_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, rd);
    end

    chk("we outside busy", 32'(we_viol), 32'd0);
    bad = 0;
    for (int i = 0; i < MSZ; i++) if (mem[i] !== gold[i]) bad++;
    chk("final memory image", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmem_byte_arbiter.md
Name: dmem_byte_arbiter

Overview:
- Shares one byte-wide data memory (8-bit word, synchronous 1-cycle read) between two 32-bit word requesters.
- Port A is the CPU MEM stage (lw/sw); port B is the DMA / test-loader port.
- Serialises each word access into four little-endian byte beats.
- Arbitrates round-robin and returns a one-cycle ack with assembled read data.

Parameters:
- ADDR_W, 5, byte-address width of the backing memory (2^ADDR_W bytes; 5 gives 32 bytes).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- a_req_i  in  1  port A request; held with a_we_i/a_addr_i/a_wdata_i stable until a_ack_o.
- a_we_i  in  1  port A: 1=word write, 0=word read.
- a_addr_i  in  32  port A byte address; bits above ADDR_W ignored.
- a_wdata_i  in  32  port A write data.
- a_ack_o  out  1  port A one-cycle completion pulse.
- a_rdata_o  out  32  port A read data, valid with a_ack_o of a read.
- b_req_i, b_we_i, b_addr_i, b_wdata_i, b_ack_o, b_rdata_o: same as port A, for port B.
- mem_addr_o  out  ADDR_W  byte address to memory.
- mem_we_o  out  1  byte write strobe.
- mem_wdata_o  out  8  byte write data.
- mem_rdata_i  in  8  byte read data for the address presented in the previous cycle.
- busy_o  out  1  high in BUSY and RESP.
- grant_o  out  1  current or last owner (0=A, 1=B).

Behaviour:
- Reset (rst_i high at posedge):
  - state=IDLE, beat=0, last_grant=1 (so A wins the first tie).
  - All acks, mem_we_o, busy_o, mem_addr_o, mem_wdata_o, a_rdata_o, b_rdata_o and grant_o go to 0.
- IDLE:
  - If any req is high, grant one requester; latch its addr[ADDR_W-1:0], we and wdata.
  - Set grant_o and last_grant, beat=0, go to BUSY.
  - Arbitration: only A requests -> A; only B -> B; both -> the port not equal to last_grant.
- BUSY (4 cycles, beat 0..3):
  - mem_addr_o = base+beat, modulo 2^ADDR_W, so the address wraps past the top byte.
  - Write: mem_we_o=1, mem_wdata_o = wdata[8*beat+7:8*beat].
  - Read: mem_we_o=0; at beat k>0 capture mem_rdata_i into data byte k-1.
  - At beat 3 go to RESP.
- RESP (1 cycle):
  - For a read, capture mem_rdata_i into byte 3.
  - Pulse the granted port's ack. The read data appears on that port's rdata_o in the same cycle as ack.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle 0; ack asserted in cycle 5. Reads and writes take the same time. Throughput is one word per 6 cycles.
- rdata_o of a port updates only on that port's read completion; otherwise it holds its value.
- Requester protocol:
  - The requester must drop req at the edge where its ack is high.
  - A req still high in the IDLE cycle after ack is a new transaction.
- Request changes:
  - Latched fields make changes to req or fields during BUSY/RESP have no effect on the transaction in flight.
  - A request from the other port waits (no ack) until IDLE.
- Unaligned addresses are legal: bytes go to base..base+3 with wrap.
- Memory-level effects:
  - mem_we_o is never high outside BUSY.
  - A write with ADDR_W=5 at 0x1E touches bytes 0x1E, 0x1F, 0x00, 0x01.
- Reset mid-operation:
  - Return to IDLE immediately; no ack is issued.
  - Bytes already written stay written (no rollback).
  - The requester must reissue.

Test Plan:
1. A write 0x11223344 @0x04, then A read @0x04:
   - During the write, mem beats write 44,33,22,11 to 04..07.
   - The read returns a_rdata_o=0x11223344 with a_ack_o exactly 5 cycles after req is sampled.
2. A and B both request from reset (A read @0x00, B write 0xDEADBEEF @0x08):
   - A is granted first.
   - B is acked 6 cycles later.
   - A second simultaneous pair is granted to A again, because last_grant=B.
3. B writes 0xCAFEF00D @0x1E (ADDR_W=5) -> mem_addr_o sequence 1E,1F,00,01. A read @0x1E returns 0xCAFEF00D.
4. B request arrives while A is in BUSY -> b_ack_o stays low until A's ack. B is granted in the next IDLE. Changing a_addr_i mid-BUSY does not alter the address sequence.
5. rst_i asserted at beat 2 of an A write 0xAABBCCDD @0x10:
   - Next cycle is IDLE, busy_o=0, no ack.
   - Bytes 0x10 and 0x11 hold DD and CC; bytes 0x12 and 0x13 are unchanged.
6. A read ack followed by req held high one extra cycle -> a second full read is issued, with a second ack 6 cycles later. b_rdata_o is unchanged throughout.
